// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register write-pending scoreboard.
//
// Decode reads operands combinationally and issues instructions. Each issued
// write to a non-zero rd bumps a small saturating pending counter for that
// register. The writeback stage retires pending writes. A stall (hazard_o) is
// raised when an operand still has a write in flight, or when the destination
// counter is already full.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rs1_i/rs2_i, rsN_used_i    source indices and read qualifiers from decode
//   rs1_data_o/rs2_data_o      operands, with write-through bypass from writeback
//   issue_i/issue_rd_i/issue_wr_i  instruction issue from decode
//   hazard_o                   stall request, independent of issue_i
//   wb_en_i/wb_rd_i/wb_data_i  writeback port
//   underflow_o                sticky: a writeback arrived with nothing pending
module regfile_scoreboard #(
  parameter int unsigned       AWIDTH   = 32,
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [AWIDTH-1:0] SP_RESET = 32'h0110_0000,
  parameter int unsigned       CWIDTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  output logic [DWIDTH-1:0] rs1_data_o,
  output logic [DWIDTH-1:0] rs2_data_o,
  input  logic              issue_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              issue_wr_i,
  output logic              hazard_o,
  input  logic              wb_en_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [DWIDTH-1:0] wb_data_i,
  output logic              underflow_o
);

  localparam int unsigned    NumRegs = 32;
  localparam logic [CWIDTH-1:0] CntMax  = '1;
  localparam logic [CWIDTH-1:0] CntOne  = CWIDTH'(1);

  logic [DWIDTH-1:0] regs_q [NumRegs];
  logic [CWIDTH-1:0] cnt_q  [NumRegs];
  logic [CWIDTH-1:0] cnt_d  [NumRegs];
  logic              underflow_q, underflow_d;

  logic wb_go;      // writeback to a real register
  logic issue_go;   // issue that actually claims a counter slot
  logic rs1_pend, rs2_pend, rd_full;

  assign wb_go = wb_en_i & (wb_rd_i != 5'd0);

  // A register is not pending if its last outstanding write retires this cycle,
  // since the bypass already delivers the value.
  assign rs1_pend = (cnt_q[rs1_i] != '0) &&
                    !(wb_en_i && (wb_rd_i == rs1_i) && (cnt_q[rs1_i] == CntOne));
  assign rs2_pend = (cnt_q[rs2_i] != '0) &&
                    !(wb_en_i && (wb_rd_i == rs2_i) && (cnt_q[rs2_i] == CntOne));
  // Saturation guard: never let a counter wrap.
  assign rd_full  = cnt_q[issue_rd_i] == CntMax;

  assign hazard_o = (rs1_used_i & (rs1_i != 5'd0) & rs1_pend) |
                    (rs2_used_i & (rs2_i != 5'd0) & rs2_pend) |
                    (issue_wr_i & (issue_rd_i != 5'd0) & rd_full);

  assign issue_go = issue_i & issue_wr_i & (issue_rd_i != 5'd0) & ~hazard_o;

  // Operand read with write-through bypass; x0 is hard-wired to zero.
  always_comb begin
    rs1_data_o = '0;
    if (rs1_i != 5'd0) begin
      if (wb_en_i && (wb_rd_i == rs1_i)) begin
        rs1_data_o = wb_data_i;
      end else begin
        rs1_data_o = regs_q[rs1_i];
      end
    end
  end

  always_comb begin
    rs2_data_o = '0;
    if (rs2_i != 5'd0) begin
      if (wb_en_i && (wb_rd_i == rs2_i)) begin
        rs2_data_o = wb_data_i;
      end else begin
        rs2_data_o = regs_q[rs2_i];
      end
    end
  end

  // Counter next state. A simultaneous issue and retire to one register cancel.
  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_go && (issue_rd_i == 5'(r))) begin
        if (!(wb_go && (wb_rd_i == 5'(r)) && (cnt_q[r] != '0))) begin
          cnt_d[r] = cnt_q[r] + CntOne;
        end
      end else if (wb_go && (wb_rd_i == 5'(r)) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
  end

  // A retire with nothing pending is a pipeline bookkeeping error; latch it.
  assign underflow_d = underflow_q | (wb_go & (cnt_q[wb_rd_i] == '0));
  assign underflow_o = underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_q[r] <= (r == 2) ? DWIDTH'(SP_RESET) : '0;
      end
    end else if (wb_go) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Architectural register file plus per-register write-pending scoreboard for the pipelined core. It is the consumer end of the writeback interface: it takes rd/data from the writeback stage and serves operands to decode. It tracks in-flight writes issued by decode and raises a hazard/stall when a source or destination register is not safe to use.

Parameters:
AWIDTH, 32, address width (sets the width of SP_RESET only)
DWIDTH, 32, register data width
SP_RESET, 32'h0110_0000, reset value of x2 (sp)
CWIDTH, 2, width of each per-register pending counter (saturates at 2^CWIDTH-1)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rs1_i  input  5  source 1 index
rs2_i  input  5  source 2 index
rs1_used_i  input  1  instruction reads rs1
rs2_used_i  input  1  instruction reads rs2
rs1_data_o  output  DWIDTH  source 1 operand (combinational)
rs2_data_o  output  DWIDTH  source 2 operand (combinational)
issue_i  input  1  decode issues an instruction this cycle
issue_rd_i  input  5  destination of issued instruction
issue_wr_i  input  1  issued instruction writes rd
hazard_o  output  1  stall request (combinational)
wb_en_i  input  1  writeback write enable
wb_rd_i  input  5  writeback destination
wb_data_i  input  DWIDTH  writeback data
underflow_o  output  1  sticky error: writeback with no pending issue

Behaviour:
- One clock `clk`; `reset` is synchronous and active-high.
- Reset, on the next edge:
  - All registers are 0, except x2 = SP_RESET.
  - All pending counters are 0.
  - underflow_o = 0.
- Reset asserted mid-stream overrides any simultaneous issue or writeback.
- x0:
  - Reads always return 0.
  - Writes to x0 are dropped.
  - Issue with rd=0 does not touch any counter.
  - Writeback to x0 does not touch any counter.
- Write: on a clk edge with wb_en_i=1 and wb_rd_i!=0, reg[wb_rd_i] <= wb_data_i.
- Read: combinational.
  - If wb_en_i=1, wb_rd_i==rsN_i and rsN_i!=0, rsN_data_o = wb_data_i (write-through bypass).
  - Otherwise rsN_data_o = reg[rsN_i].
- Counter per register, cnt[r], CWIDTH bits, updated on the edge:
  - inc = issue_i & issue_wr_i & (issue_rd_i==r) & !hazard_o & r!=0.
  - dec = wb_en_i & (wb_rd_i==r) & r!=0 & cnt[r]!=0.
  - inc & dec: unchanged. inc only: +1. dec only: -1.
- Writeback to r!=0 while cnt[r]==0:
  - The data is still written.
  - The counter stays 0.
  - underflow_o is set and stays 1 until reset.
- hazard_o (combinational) is the OR of:
  - rs1_used_i & rs1_i!=0 & pend(rs1_i)
  - rs2_used_i & rs2_i!=0 & pend(rs2_i)
  - issue_wr_i & issue_rd_i!=0 & cnt[issue_rd_i]==max (saturation guard)
- pend(r) = cnt[r]!=0, except it is 0 when wb_en_i & wb_rd_i==r & cnt[r]==1 (the last outstanding write is retiring now and is bypassed).
- hazard_o depends only on the current inputs and state, and is independent of issue_i.
- Issue while hazard_o=1 is ignored: no counter change. Decode holds the instruction and retries.
- Latency:
  - Write visible on the read ports in the same cycle via the bypass, and from storage the cycle after.
  - Counter effects visible the cycle after the edge.

Test Plan:
1. Reset, then read rs1=2, rs2=0 -> rs1_data_o=0x01100000, rs2_data_o=0, hazard_o=0, underflow_o=0.
2. Issue rd=5 (issue_wr=1); next cycle rs1=5 with rs1_used=1 -> hazard_o=1. Writeback rd=5 data 0xDEADBEEF in the same cycle -> hazard_o=0, rs1_data_o=0xDEADBEEF. Following cycle -> cnt[5]=0 and reg[5]=0xDEADBEEF.
3. Writeback rd=0 data 0xCAFEBABE -> rs1=0 reads 0. Issue rd=0 then rs1=0 with rs1_used=1 -> hazard_o=0.
4. Issue rd=7 three times with no writeback -> cnt=3. A fourth issue to rd=7 -> hazard_o=1 and the count stays 3. Three writebacks to rd=7 -> the count drains to 0; hazard clears on the third via the bypass.
5. Issue rd=9 and writeback rd=9 (cnt[9]=1) in the same cycle -> cnt[9] stays 1 and reg[9] takes the wb data.
6. Writeback rd=12 with cnt[12]=0 -> reg[12] is written and underflow_o=1 next cycle, staying high. Assert reset -> underflow_o=0, all counts 0, x2=SP_RESET.
